// File: rtl/cmd_proc_if.sv
// UART_comm <-> cmd_proc handshake bundle: command in, response byte out.
interface cmd_proc_if;
  logic        cmd_rdy;
  logic [23:0] cmd;
  logic        tx_done;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  tx_data;

  modport master (output cmd_rdy, cmd, tx_done, input  clr_cmd_rdy, trmt, tx_data);
  modport slave  (input  cmd_rdy, cmd, tx_done, output clr_cmd_rdy, trmt, tx_data);
endinterface

// File: rtl/cmd_proc.sv
// Command processor behind UART_comm: decodes write/read/ping against an 8-bit regfile
// and returns one response byte. Optional tx watchdog enabled by CMD_PROC_WDOG_EN.
module cmd_proc #(
  parameter int          NUM_REGS   = 8,
  parameter logic [7:0]  ACK_BYTE   = 8'hA5,
  parameter logic [7:0]  NAK_BYTE   = 8'hEE,
  parameter int          TX_TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  cmd_proc_if.slave             uif,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  busy,
  output logic                  tx_err
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, SEND, WAIT} state_t;

  state_t                     state_q, state_d;
  logic [23:0]                cmd_q, cmd_d;
  logic [7:0]                 resp_q, resp_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       clr_q, clr_d;
  logic                       trmt_q, trmt_d;
  logic                       busy_q, busy_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;

  logic [7:0] op, addr, data;
  logic       addr_ok;

  assign op   = cmd_q[23:16];
  assign addr = cmd_q[15:8];
  assign data = cmd_q[7:0];
  // Full 8-bit unsigned compare so out-of-range addresses never alias onto low bits.
  assign addr_ok = ({24'd0, addr} < NUM_REGS);

  if (TX_TIMEOUT < 1) begin : g_bad_cfg
    $error("cmd_proc: TX_TIMEOUT must be positive");
  end

`ifdef CMD_PROC_WDOG_EN
  localparam int CW = $clog2(TX_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_err_q, tx_err_d;
  assign tx_err = tx_err_q;
`else
  assign tx_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    tx_data_d = tx_data_q;
    clr_d     = 1'b0;
    trmt_d    = 1'b0;
    busy_d    = busy_q;
    regs_d    = regs_q;
`ifdef CMD_PROC_WDOG_EN
    cnt_d     = cnt_q;
    tx_err_d  = tx_err_q;
`endif
    case (state_q)
      IDLE: if (uif.cmd_rdy) begin
        cmd_d   = uif.cmd;
        clr_d   = 1'b1;
        busy_d  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        resp_d  = NAK_BYTE;
        state_d = SEND;
        case (op)
          8'h01: if (addr_ok) begin
            regs_d[addr[AW-1:0]] = data;
            resp_d               = ACK_BYTE;
          end
          8'h02: if (addr_ok) resp_d = regs_q[addr[AW-1:0]];
          8'h03: resp_d = ACK_BYTE;
          default: ;
        endcase
      end
      SEND: begin
        trmt_d    = 1'b1;
        tx_data_d = resp_q;
        state_d   = WAIT;
`ifdef CMD_PROC_WDOG_EN
        cnt_d     = '0;
`endif
      end
      WAIT: begin
        // tx_done during the trmt cycle may be stale from the previous byte.
        if (!trmt_q && uif.tx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`ifdef CMD_PROC_WDOG_EN
        else if (cnt_q == CW'(TX_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      resp_q    <= '0;
      tx_data_q <= '0;
      clr_q     <= 1'b0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      regs_q    <= '0;
`ifdef CMD_PROC_WDOG_EN
      cnt_q     <= '0;
      tx_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      tx_data_q <= tx_data_d;
      clr_q     <= clr_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
`ifdef CMD_PROC_WDOG_EN
      cnt_q     <= cnt_d;
      tx_err_q  <= tx_err_d;
`endif
    end
  end

  assign uif.clr_cmd_rdy = clr_q;
  assign uif.trmt        = trmt_q;
  assign uif.tx_data     = tx_data_q;
  assign regs            = regs_q;
  assign busy            = busy_q;
endmodule

// File: tb/tb_cmd_proc.sv
// Self-checking bench for cmd_proc: latency sequence, vector table, corner sequences,
// and randomized commands against a register-array reference model.
module tb_cmd_proc;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] regs;
  logic        busy, tx_err;

  cmd_proc_if uif ();

  cmd_proc #(.NUM_REGS(8), .ACK_BYTE(ACK), .NAK_BYTE(NAK), .TX_TIMEOUT(100)) dut (
    .clk    (clk),
    .rst    (rst),
    .uif    (uif),
    .regs   (regs),
    .busy   (busy),
    .tx_err (tx_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int clr_cnt = 0;
  int trmt_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (uif.clr_cmd_rdy) clr_cnt <= clr_cnt + 1;
    if (uif.trmt)        trmt_cnt <= trmt_cnt + 1;
  end

  // Reference register file: plain array, updated per command.
  logic [7:0] mregs [8];

  function automatic logic [7:0] model(input logic [23:0] c);
    logic [7:0] op, a, d;
    op = c[23:16]; a = c[15:8]; d = c[7:0];
    if (op == 8'h01) begin
      if (a < 8) begin mregs[a] = d; return ACK; end
      return NAK;
    end
    if (op == 8'h02) return (a < 8) ? mregs[a] : NAK;
    if (op == 8'h03) return ACK;
    return NAK;
  endfunction

  function automatic logic [63:0] mflat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic send_req(input logic [23:0] c);
    int n;
    n = 0;
    @(negedge clk);
    uif.cmd = c;
    uif.cmd_rdy = 1'b1;
    do begin @(negedge clk); n++; end while (!uif.clr_cmd_rdy && n < 200);
    if (!uif.clr_cmd_rdy) expired("clr_cmd_rdy wait");
    uif.cmd_rdy = 1'b0;
  endtask

  task automatic wait_trmt(output logic [7:0] d);
    int n;
    n = 0;
    while (!uif.trmt && n < 200) begin @(negedge clk); n++; end
    if (!uif.trmt) expired("trmt wait");
    d = uif.tx_data;
  endtask

  task automatic finish_tx();
    int n;
    n = 0;
    uif.tx_done = 1'b1;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    if (busy) expired("busy release");
    uif.tx_done = 1'b0;
  endtask

  task automatic do_cmd(input logic [23:0] c, input int hold, output logic [7:0] got);
    int c0, t0;
    c0 = clr_cnt; t0 = trmt_cnt;
    send_req(c);
    wait_trmt(got);
    repeat (hold) @(negedge clk);
    finish_tx();
    chk("regs", regs, mflat());
    chk("clr pulses", 64'(clr_cnt - c0), 64'd1);
    chk("trmt pulses", 64'(trmt_cnt - t0), 64'd1);
  endtask

  typedef struct { logic [23:0] cmd; logic [7:0] resp; } vec_t;
  vec_t tbl [12];

  initial begin
    logic [7:0] got, exp;
    int c0, t0;

    tbl[0]  = '{24'h020300, 8'h5A};
    tbl[1]  = '{24'h030000, ACK};
    tbl[2]  = '{24'h7F0011, NAK};
    tbl[3]  = '{24'h010899, NAK};
    tbl[4]  = '{24'h01FF77, NAK};
    tbl[5]  = '{24'h020800, NAK};
    tbl[6]  = '{24'h010000, ACK};
    tbl[7]  = '{24'h0107C3, ACK};
    tbl[8]  = '{24'h020700, 8'hC3};
    tbl[9]  = '{24'h000000, NAK};
    tbl[10] = '{24'h02FF00, NAK};
    tbl[11] = '{24'h020000, 8'h00};

    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    uif.cmd_rdy = 1'b0; uif.cmd = '0; uif.tx_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset trmt", uif.trmt, 0);
    chk("reset clr", uif.clr_cmd_rdy, 0);
    chk("reset tx_data", uif.tx_data, 0);
    chk("reset regs", regs, 0);
    chk("reset tx_err", tx_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Cycle-exact latency of a write.
    exp = model(24'h01035A);
    uif.cmd = 24'h01035A; uif.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("lat clr", uif.clr_cmd_rdy, 1);
    chk("lat busy", busy, 1);
    chk("lat reg3 pre", regs[31:24], 0);
    uif.cmd_rdy = 1'b0;
    @(negedge clk);
    chk("lat clr drop", uif.clr_cmd_rdy, 0);
    chk("lat reg3", regs[31:24], 8'h5A);
    chk("lat trmt early", uif.trmt, 0);
    @(negedge clk);
    chk("lat trmt", uif.trmt, 1);
    chk("lat tx_data", uif.tx_data, exp);
    @(negedge clk);
    chk("lat trmt one", uif.trmt, 0);
    chk("lat tx_data hold", uif.tx_data, ACK);
    finish_tx();

    foreach (tbl[i]) begin
      exp = model(tbl[i].cmd);
      do_cmd(tbl[i].cmd, i % 3, got);
      chk($sformatf("tbl[%0d] resp", i), got, tbl[i].resp);
    end

    // Second command held through a long WAIT must be taken exactly once.
    c0 = clr_cnt; t0 = trmt_cnt;
    exp = model(24'h010611);
    send_req(24'h010611);
    wait_trmt(got);
    chk("held A resp", got, exp);
    uif.cmd = 24'h020600; uif.cmd_rdy = 1'b1;
    repeat (50) @(negedge clk);
    chk("held no clr", 64'(clr_cnt - c0), 64'd1);
    chk("held busy", busy, 1);
    uif.tx_done = 1'b1;
    @(negedge clk);
    uif.tx_done = 1'b0;
    @(negedge clk);
    chk("held clr taken", uif.clr_cmd_rdy, 1);
    uif.cmd_rdy = 1'b0;
    exp = model(24'h020600);
    wait_trmt(got);
    chk("held B resp", got, exp);
    finish_tx();
    repeat (5) @(negedge clk);
    chk("held clr total", 64'(clr_cnt - c0), 64'd2);
    chk("held trmt total", 64'(trmt_cnt - t0), 64'd2);

    // Reset in WAIT after a write.
    send_req(24'h01042B);
    wait_trmt(got);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst regs", regs, 0);
    chk("rst trmt", uif.trmt, 0);
    chk("rst tx_data", uif.tx_data, 0);
    chk("rst busy", busy, 0);
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    exp = model(24'h020400);
    do_cmd(24'h020400, 1, got);
    chk("post rst read", got, exp);
    exp = model(24'h01012C);
    do_cmd(24'h01012C, 0, got);
    chk("post rst write", got, exp);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op, a, d;
      case ($urandom_range(0, 3))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        default: op = 8'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      d = 8'($urandom);
      exp = model({op, a, d});
      do_cmd({op, a, d}, $urandom_range(0, 5), got);
      chk($sformatf("rand[%0d] %02h%02h%02h", i, op, a, d), got, exp);
    end

    // tx_done never arrives.
    send_req(24'h030000);
    wait_trmt(got);
    repeat (150) @(negedge clk);
`ifdef CMD_PROC_WDOG_EN
    chk("wdog tx_err", tx_err, 1);
    chk("wdog busy", busy, 0);
`else
    chk("no wdog tx_err", tx_err, 0);
    chk("no wdog busy", busy, 1);
    finish_tx();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
